collision_probe: RTL and testbench

Per-frame collision detector between the VGA timing chain and the ball-motion logic. It watches the pixel-stream object mask (border/paddles) at four probe points around the ball. Once per video frame it publishes registered left/right/top/bottom collision flags with a one-cycle strobe. The ball-motion block consumes these flags to reverse its X/Y direction.

---
 rtl/collision_probe.sv | 118 +++++++++++
 tb/tb_collision_probe.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/collision_probe.sv
// Per-frame ball collision detector: samples the object mask at four probe points
// on the ball's bounding box and publishes the frame's hit flags with a strobe.
module collision_probe #(
   parameter int unsigned BALL_SIZE   = 8,
   parameter int unsigned REPORT_LINE = 480,
   parameter int unsigned H_MAX       = 799,
   parameter int unsigned V_MAX       = 524
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pix_en,
   input  logic       valid,
   input  logic [9:0] h_cnt,
   input  logic [9:0] v_cnt,
   input  logic       obj_mask,
   input  logic [9:0] ballX,
   input  logic [9:0] ballY,
   output logic       coll_left,
   output logic       coll_right,
   output logic       coll_top,
   output logic       coll_bottom,
   output logic       coll_strobe,
   input  logic       coll_ack
);

   localparam logic [10:0] HALF  = 11'(BALL_SIZE / 2);
   localparam logic [10:0] SIZE  = 11'(BALL_SIZE);
   localparam logic [10:0] HLIM  = 11'(H_MAX);
   localparam logic [10:0] VLIM  = 11'(V_MAX);
   localparam logic [9:0]  RLINE = 10'(REPORT_LINE);

   typedef enum logic [1:0] {
      WAIT_FRAME,
      SCAN,
      REPORT
   } state_t;

   state_t     state_q;
   logic [9:0] bx_q, by_q;
   logic [3:0] acc_q;     // {left, right, top, bottom}
   logic [3:0] flags_q;
   logic       strobe_q;

   logic [10:0] h11, v11, bx11, by11;
   logic [3:0]  hit_vec;
   logic        frame_start, report_pix;

   // Probes beyond the frame limits never match, so no wrap-around hits occur.
   function automatic logic at_probe(input logic [10:0] px, input logic [10:0] py,
                                     input logic [10:0] hh, input logic [10:0] vv);
      return (px <= HLIM) && (py <= VLIM) && (hh == px) && (vv == py);
   endfunction

   always_comb begin
      h11  = {1'b0, h_cnt};
      v11  = {1'b0, v_cnt};
      bx11 = {1'b0, bx_q};
      by11 = {1'b0, by_q};
      hit_vec    = '0;
      hit_vec[3] = at_probe(bx11,        by11 + HALF, h11, v11);
      hit_vec[2] = at_probe(bx11 + SIZE, by11 + HALF, h11, v11);
      hit_vec[1] = at_probe(bx11 + HALF, by11,        h11, v11);
      hit_vec[0] = at_probe(bx11 + HALF, by11 + SIZE, h11, v11);
      frame_start = pix_en && (h_cnt == '0) && (v_cnt == '0);
      report_pix  = pix_en && (h_cnt == '0) && (v_cnt == RLINE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= WAIT_FRAME;
         bx_q     <= '0;
         by_q     <= '0;
         acc_q    <= '0;
         flags_q  <= '0;
         strobe_q <= 1'b0;
      end else begin
         strobe_q <= 1'b0;
         if (coll_ack)
            flags_q <= '0;
         unique case (state_q)
            WAIT_FRAME: begin
               if (frame_start) begin
                  bx_q    <= ballX;
                  by_q    <= ballY;
                  acc_q   <= '0;
                  state_q <= SCAN;
               end
            end
            SCAN: begin
               // A fresh frame start without a report line restarts the scan.
               if (frame_start) begin
                  bx_q  <= ballX;
                  by_q  <= ballY;
                  acc_q <= '0;
               end else if (pix_en) begin
                  if (valid && obj_mask)
                     acc_q <= acc_q | hit_vec;
                  if (report_pix)
                     state_q <= REPORT;
               end
            end
            REPORT: begin
               flags_q  <= acc_q;
               strobe_q <= 1'b1;
               state_q  <= WAIT_FRAME;
            end
            default: state_q <= WAIT_FRAME;
         endcase
      end
   end

   assign coll_left   = flags_q[3];
   assign coll_right  = flags_q[2];
   assign coll_top    = flags_q[1];
   assign coll_bottom = flags_q[0];
   assign coll_strobe = strobe_q;

endmodule

// File: tb/tb_collision_probe.sv
// Directed bench for collision_probe: drives only the pixels that matter
// (frame start, probe neighbourhoods, report line) with a bench-side mask model.
module tb_collision_probe;

   logic       clk = 1'b0;
   logic       rst, pix_en, valid, obj_mask, coll_ack;
   logic [9:0] h_cnt, v_cnt, ballX, ballY;
   logic       coll_left, coll_right, coll_top, coll_bottom, coll_strobe;

   int vectors     = 0;
   int miscompares = 0;

   int wall = -1;
   int col  = -1;
   int row  = -1;
   bit all_mask    = 1'b0;
   bit force_valid = 1'b0;

   always #5 clk = ~clk;

   collision_probe #(
      .BALL_SIZE  (8),
      .REPORT_LINE(480),
      .H_MAX      (799),
      .V_MAX      (524)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .pix_en     (pix_en),
      .valid      (valid),
      .h_cnt      (h_cnt),
      .v_cnt      (v_cnt),
      .obj_mask   (obj_mask),
      .ballX      (ballX),
      .ballY      (ballY),
      .coll_left  (coll_left),
      .coll_right (coll_right),
      .coll_top   (coll_top),
      .coll_bottom(coll_bottom),
      .coll_strobe(coll_strobe),
      .coll_ack   (coll_ack)
   );

   function automatic logic mask_at(int h, int v);
      return (wall >= 0 && h <= wall) || (col >= 0 && h == col) ||
             (row >= 0 && v == row) || all_mask;
   endfunction

   function automatic logic valid_at(int h, int v);
      return force_valid || (h < 640 && v < 480);
   endfunction

   // Expected {left,right,top,bottom} for a snapshot at (x,y), ball size 8.
   function automatic logic [3:0] model(int x, int y);
      int px[4] = '{x, x + 8, x + 4, x + 4};
      int py[4] = '{y + 4, y + 4, y, y + 8};
      logic [3:0] e = '0;
      for (int i = 0; i < 4; i++)
         e[3-i] = (px[i] <= 799) && (py[i] <= 524) &&
                  valid_at(px[i], py[i]) && mask_at(px[i], py[i]);
      return e;
   endfunction

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic pix(input int h, input int v);
      h_cnt    = 10'(h);
      v_cnt    = 10'(v);
      valid    = valid_at(h, v);
      obj_mask = mask_at(h, v);
      pix_en   = 1'b1;
      @(negedge clk);
      pix_en   = 1'b0;
      valid    = 1'b0;
      obj_mask = 1'b0;
   endtask

   task automatic start_frame(input int x, input int y);
      ballX = 10'(x);
      ballY = 10'(y);
      pix(0, 0);
   endtask

   task automatic scan(input int x, input int y);
      int px[4] = '{x, x + 8, x + 4, x + 4};
      int py[4] = '{y + 4, y + 4, y, y + 8};
      for (int i = 0; i < 4; i++)
         for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++) begin
               int h = px[i] + dx;
               int v = py[i] + dy;
               if (h >= 0 && v >= 0 && h <= 1023 && v <= 1023 &&
                   !(h == 0 && (v == 0 || v == 480)))
                  pix(h, v);
            end
   endtask

   function automatic logic [3:0] flags();
      return {coll_left, coll_right, coll_top, coll_bottom};
   endfunction

   task automatic report_check(input string tag, input logic [3:0] exp);
      check({tag, "_nostrobe_scan"}, {3'b0, coll_strobe}, 4'b0);
      pix(0, 480);
      check({tag, "_nostrobe_rep"}, {3'b0, coll_strobe}, 4'b0);
      @(negedge clk);
      check({tag, "_strobe"}, {3'b0, coll_strobe}, 4'b1);
      check({tag, "_flags"}, flags(), exp);
      @(negedge clk);
      check({tag, "_strobe_1clk"}, {3'b0, coll_strobe}, 4'b0);
   endtask

   initial begin
      rst = 1'b1; pix_en = 1'b0; valid = 1'b0; obj_mask = 1'b0; coll_ack = 1'b0;
      h_cnt = '0; v_cnt = '0; ballX = '0; ballY = '0;
      repeat (3) @(negedge clk);
      check("reset_flags", flags(), 4'b0000);
      check("reset_strobe", {3'b0, coll_strobe}, 4'b0);
      rst = 1'b0;

      // Free frames
      start_frame(300, 200); scan(300, 200); report_check("free1", 4'b0000);
      start_frame(300, 200); scan(300, 200); report_check("free2", model(300, 200));

      // Left wall at columns 0..7
      wall = 7;
      start_frame(8, 100); scan(8, 100); report_check("wall8", model(8, 100));
      start_frame(7, 100); scan(7, 100); report_check("wall7", 4'b1000);
      repeat (4) @(negedge clk);
      check("hold_no_ack", flags(), 4'b1000);

      // Corner: column 632 and row 0 cover right and top probes; overwrites left
      wall = -1; col = 632; row = 0;
      start_frame(624, 0); scan(624, 0); report_check("corner", 4'b0110);

      // Off-screen probes never match even with mask and valid forced high
      col = -1; row = -1; all_mask = 1'b1; force_valid = 1'b1;
      start_frame(795, 520); scan(795, 520); report_check("offscreen", 4'b1010);
      all_mask = 1'b0; force_valid = 1'b0;

      // Snapshot: mid-frame ball move is ignored until next frame
      wall = 7;
      start_frame(100, 100);
      ballX = 10'd7; ballY = 10'd100;
      scan(100, 100); scan(7, 100);
      report_check("snap_old", 4'b0000);
      start_frame(7, 100); scan(7, 100); report_check("snap_new", 4'b1000);

      // Acknowledge clears, repeated ack has no effect
      coll_ack = 1'b1; @(negedge clk); coll_ack = 1'b0;
      check("ack_clear", flags(), 4'b0000);
      coll_ack = 1'b1; @(negedge clk); coll_ack = 1'b0;
      check("ack_idle", flags(), 4'b0000);

      // pix_en low holds SCAN at the report line; then ack coinciding with REPORT
      start_frame(7, 100); scan(7, 100);
      h_cnt = 10'd0; v_cnt = 10'd480; pix_en = 1'b0;
      repeat (3) @(negedge clk);
      check("pixen_hold_strobe", {3'b0, coll_strobe}, 4'b0);
      pix(0, 480);
      coll_ack = 1'b1; @(negedge clk); coll_ack = 1'b0;
      check("ack_vs_report_strobe", {3'b0, coll_strobe}, 4'b1);
      check("ack_vs_report_flags", flags(), 4'b1000);

      // Missed report line: next frame start discards the stale hit
      start_frame(7, 100); scan(7, 100);
      wall = -1;
      start_frame(300, 200); scan(300, 200); report_check("no_report_line", 4'b0000);

      // Reset mid-frame
      wall = 7;
      start_frame(7, 100); scan(7, 100); report_check("pre_reset", 4'b1000);
      start_frame(7, 100); scan(7, 100); pix(0, 240);
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      check("midreset_flags", flags(), 4'b0000);
      pix(0, 480);
      @(negedge clk);
      check("midreset_nostrobe1", {3'b0, coll_strobe}, 4'b0);
      @(negedge clk);
      check("midreset_nostrobe2", {3'b0, coll_strobe}, 4'b0);
      start_frame(7, 100); scan(7, 100); report_check("post_reset", 4'b1000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
